// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank divider bank: default counter width,
// load-FSM state encoding and a clog2 helper that never returns zero.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } load_state_e;

    // Width of a channel-select field; at least one bit even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, divisor register, registered tick and square
// wave. A pending divisor is written through `apply`, which the top level only
// raises on this channel's terminal-count cycle or while the channel is stalled.
// `align` (driven only when CLKDIV_ALIGN_EN is defined at the top) clears the
// counter and square wave so every channel restarts in phase with a reload.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(50000)
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             en,
    input  logic             apply,
    input  logic [CNT_W-1:0] apply_div,
    input  logic             align,
    output logic             tc,
    output logic             stall,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // Stall and terminal-count decode; compare is unsigned, cnt never passes div-1.
    always_comb begin
        stall = !en || (div_q == '0);
        tc    = !stall && (cnt_q == (div_q - ONE));
    end

    // Next counter/divisor/output state, with reload and phase-align overrides.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (tc) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
        end else if (!stall) begin
            cnt_d = cnt_q + ONE;
        end
        // Reload: new divisor counts from zero starting next cycle.
        if (apply) begin
            div_d = apply_div;
            cnt_d = '0;
        end
        // Phase alignment: the reload target keeps its tick, everyone else is silenced.
        if (align) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (!apply) begin
                tick_d = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable generator. Each channel produces a
// one-cycle tick every N cycles and a square wave of period 2N. Divisors are
// reloaded at runtime through a valid/ready port and applied glitch-free at the
// target channel's next terminal count.
// Build option: define CLKDIV_ALIGN_EN to clear every channel's counter and
// square wave in the cycle a reload is applied (phase-aligned reload).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                        CHANNELS = 4,
    parameter int                        CNT_W    = CNT_W_DEF,
    parameter logic [CHANNELS*CNT_W-1:0] DIV_INIT = {CHANNELS{CNT_W'(50000)}},
    localparam int                       LCH_W    = clog2_min1(CHANNELS)
) (
    input  logic                clk_100M,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [LCH_W-1:0]    load_ch,
    input  logic [CNT_W-1:0]    load_div,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq
);

    localparam logic [LCH_W:0] CH_LIM = (LCH_W + 1)'(CHANNELS);

    // Handshake: a load transfers on a rising edge where load_valid && load_ready.
    // load_ready is high only in IDLE; it drops the cycle after a transfer to a
    // valid channel and returns the cycle after the divisor is applied. A load to
    // a channel number >= CHANNELS transfers but is discarded (ready stays high).

    load_state_e      state_q, state_d;
    logic [LCH_W-1:0] sh_ch_q, sh_ch_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic             applied_q, applied_d;

    logic                ch_ok;
    logic                fire;
    logic [CHANNELS-1:0] tc_vec;
    logic [CHANNELS-1:0] stall_vec;
    logic [CHANNELS-1:0] apply_vec;
    logic [CHANNELS-1:0] align_vec;

    assign ch_ok = ({1'b0, load_ch} < CH_LIM);

    // FSM state and shadow registers.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_ch_q   <= '0;
            sh_div_q  <= '0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_ch_q   <= sh_ch_d;
            sh_div_q  <= sh_div_d;
            applied_q <= applied_d;
        end
    end

    // Next state: capture into the shadow in IDLE; in PEND leave one cycle after
    // the apply so ready rises only once the new divisor is in place.
    always_comb begin
        state_d   = state_q;
        sh_ch_d   = sh_ch_q;
        sh_div_d  = sh_div_q;
        applied_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid && ch_ok) begin
                    sh_ch_d  = load_ch;
                    sh_div_d = load_div;
                    state_d  = PEND;
                end
            end
            PEND: begin
                applied_d = fire;
                if (applied_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready, and the apply strobe on terminal count or stall.
    always_comb begin
        load_ready = (state_q == IDLE);
        fire       = (state_q == PEND) && !applied_q &&
                     (tc_vec[sh_ch_q] || stall_vec[sh_ch_q]);
    end

    // Fan the apply strobe out to the target, and optionally align to all channels.
    always_comb begin
        apply_vec = '0;
        align_vec = '0;
        if (fire) begin
            apply_vec[sh_ch_q] = 1'b1;
`ifdef CLKDIV_ALIGN_EN
            align_vec = '1;
`else
            align_vec = '0;
`endif
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk_100M  (clk_100M),
            .rst       (rst),
            .en        (ch_en[i]),
            .apply     (apply_vec[i]),
            .apply_div (sh_div_q),
            .align     (align_vec[i]),
            .tc        (tc_vec[i]),
            .stall     (stall_vec[i]),
            .tick      (tick[i]),
            .sq        (sq[i])
        );
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable generator running off the 100 MHz system clock. Each channel emits a one-cycle `tick` every N cycles and a 50 %-duty square wave `sq` of period 2N. Divisors start from parameters and can be changed at runtime through a valid/ready load port; changes are applied glitch-free at the channel's next terminal count. Feeds display scan, debounce and UART-rate logic, replacing single fixed-ratio dividers.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 16: divisor and counter width in bits.
- `DIV_INIT`, {CHANNELS{16'd50000}}: packed reset divisors; channel i uses bits [i*CNT_W +: CNT_W].
- `clk_100M`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ch_en`  in  CHANNELS: per-channel run enable.
- `load_valid`  in  1: divisor load request.
- `load_ready`  out  1: block can accept a load.
- `load_ch`  in  $clog2(CHANNELS) (min 1): target channel.
- `load_div`  in  CNT_W: new divisor N.
- `tick`  out  CHANNELS: registered one-cycle pulse per period.
- `sq`  out  CHANNELS: registered square wave, toggles on every tick.

## Operation
- Reset: `cnt`=0, `tick`=0, `sq`=0, `div`=DIV_INIT, `load_ready`=1, FSM=IDLE, shadow cleared.
- Per channel, each cycle with `ch_en[i]`=1 and `div[i]`≠0:
  - `cnt`==`div`−1: `cnt`←0, `tick`←1, `sq`←~`sq`.
  - Otherwise: `cnt`←`cnt`+1, `tick`←0.
- `ch_en[i]`=0 or `div[i]`=0: `cnt` and `sq` hold, `tick`←0.
- N=1: `tick` is constantly 1 and `sq` toggles every cycle.
- Counter compare is unsigned over CNT_W bits. `cnt` never exceeds `div`−1.
- Load FSM states:
  - **IDLE**: `load_ready`=1. When `load_valid` is high, capture {`load_ch`, `load_div`} into the shadow and go to PEND.
    - If `load_ch` ≥ CHANNELS, the load is accepted and dropped, and the FSM stays in IDLE.
  - **PEND**: `load_ready`=0. The shadow is applied on the target channel's terminal-count cycle: `div`←shadow and `cnt`←0, with `tick`/`sq` behaving as a normal terminal count. The FSM then returns to IDLE.
    - If the target is stalled (`ch_en`=0 or `div`=0), the shadow is applied in the next cycle: `cnt`←0, `tick`=0, `sq` holds.
- A load accepted in the same cycle as the target's terminal count is not applied that cycle. It waits for the following terminal count.
- Reset while in PEND discards the shadow and the FSM returns to IDLE.

## Timing
- Handshake transfer occurs when `load_valid` && `load_ready` at a rising edge. `load_ready` drops in the next cycle.
- After reset release with `ch_en`=1, the first `tick` is high during cycle N (cycles counted from 1 after release). Subsequent ticks follow every N cycles.
- `sq` changes in the same cycle as `tick` rises.
- The new divisor takes effect from the cycle after the apply cycle. The next tick falls exactly N_new cycles after the apply tick.
- Maximum load-to-ready latency is old N + 1 cycles.

## Configuration
- `CLKDIV_ALIGN_EN` defined: an applied load clears `cnt`, and forces `sq`←0, on all channels in the apply cycle. Other channels emit no tick in that cycle; the target channel behaves as described under Operation. This phase-aligns every channel to the reload.
- Undefined: only the target channel is affected, and other channels run undisturbed.

## Structure
- `clk_div_pkg`: `CNT_W` default, the load-FSM state enum (`IDLE`, `PEND`), and a `clog2_min1` helper constant function.
- Sub-module `clk_div_chan`: one channel's counter, divisor register, `tick`/`sq` and apply input. It is instantiated CHANNELS times by a generate loop.
- The top level holds the load FSM, the shadow register and the align fan-out.

## Test plan
- Reset, DIV_INIT all 4, `ch_en`=4'hF → `tick` high in cycles 4, 8, 12; `sq` = 0,0,0,1,1,1,1,0 pattern; all outputs 0 during reset.
- Channel 0 with N=5: load N=3 at cycle 2 → `load_ready` low from cycle 3; apply at cycle 5 with a tick; next ticks at cycles 8 and 11; `load_ready` high at cycle 6.
- Channel 1 with `ch_en`=0: load N=2 → applied next cycle with `tick`=0; after `ch_en`→1, ticks 2 cycles later, then every 2 cycles.
- N=1 and N=0 loads → N=1 gives constant `tick`=1 and `sq` toggling every cycle; N=0 gives `tick`=0 and `sq` frozen. `load_ch`=7 with CHANNELS=4 → no divisor change and `load_ready` stays 1.
- `rst` asserted while in PEND → after release the old DIV_INIT period is restored, `load_ready`=1, and the first tick falls at cycle N.
- With `CLKDIV_ALIGN_EN`: channels at N=4 and N=6, load channel 0 → all `cnt` cleared and `sq`=0 in the apply cycle; next ticks at +4 and +6 cycles. Without the macro, channel 1 timing is unchanged.
